// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit.
//   DIV_WIDTH   : default operand width (quotient and remainder are each this wide)
//   DIV_ITER    : number of restoring iterations for the default width
//   div_state_e : 2-bit divider controller state code
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = DIV_WIDTH;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider serving DIV (signed) and DIVU (unsigned).
// EX holds start_i high while the decoded ALU control is a divide, stalls on busy_o,
// and writes result_o = {remainder, quotient} into HI/LO once ready_o is seen.
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   start_i    in   divide request, only sampled while idle
//   signed_i   in   1 = DIV, 0 = DIVU; latched with the operands
//   opdata1_i  in   dividend
//   opdata2_i  in   divisor
//   annul_i    in   pipeline flush; aborts a divide in flight
//   busy_o     out  high from acceptance until the result is ready
//   ready_o    out  result valid; held while start_i stays high
//   result_o   out  {remainder, quotient}
import div_unit_pkg::*;

module div_unit #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    // Counter must be able to hold WIDTH itself: the cycle after the last
    // iteration is spent applying the sign fixup.
    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] ITER_C  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    // Controller state
    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                busy_q,  busy_d;
    logic                ready_q, ready_d;

    // Datapath state: dvd_q shifts dividend bits out at the top and quotient
    // bits in at the bottom, so it ends up holding the unsigned quotient.
    logic [WIDTH-1:0]    dvd_q,   dvd_d;
    logic [WIDTH-1:0]    dvs_q,   dvs_d;
    logic [WIDTH-1:0]    rem_q,   rem_d;
    logic                dvd_neg_q, dvd_neg_d;
    logic                dvs_neg_q, dvs_neg_d;
    logic [2*WIDTH-1:0]  result_q, result_d;

    // Controller -> datapath strobes
    logic                load_s;
    logic                step_s;
    logic                fin_s;
    logic                zfin_s;

    // Operand conditioning and iteration step
    logic                op1_neg_s;
    logic                op2_neg_s;
    logic [WIDTH-1:0]    op1_abs_s;
    logic [WIDTH-1:0]    op2_abs_s;
    logic                div_zero_s;
    logic [WIDTH:0]      rem_ext_s;
    logic [WIDTH:0]      diff_s;
    logic                ge_s;
    logic [WIDTH-1:0]    quo_fix_s;
    logic [WIDTH-1:0]    rem_fix_s;

    // Magnitudes are taken only for DIV; the most negative value maps onto
    // itself, which is also its correct unsigned magnitude.
    assign op1_neg_s  = signed_i & opdata1_i[WIDTH-1];
    assign op2_neg_s  = signed_i & opdata2_i[WIDTH-1];
    assign op1_abs_s  = op1_neg_s ? (-opdata1_i) : opdata1_i;
    assign op2_abs_s  = op2_neg_s ? (-opdata2_i) : opdata2_i;
    assign div_zero_s = (opdata2_i == {WIDTH{1'b0}});

    // Shifted partial remainder is WIDTH+1 bits wide so its top bit is never
    // lost before the compare; the borrow of the subtraction is the compare.
    assign rem_ext_s  = {rem_q, dvd_q[WIDTH-1]};
    assign diff_s     = rem_ext_s - {1'b0, dvs_q};
    assign ge_s       = ~diff_s[WIDTH];

    // Quotient is negative when operand signs differ; remainder follows the dividend.
    assign quo_fix_s  = (dvd_neg_q ^ dvs_neg_q) ? (-dvd_q) : dvd_q;
    assign rem_fix_s  = dvd_neg_q ? (-rem_q) : rem_q;

    // Controller registers: state, iteration counter and the two handshake outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Controller next-state logic and datapath strobes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        load_s  = 1'b0;
        step_s  = 1'b0;
        fin_s   = 1'b0;
        zfin_s  = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                // A flush in the same cycle as the request wins.
                if (start_i && !annul_i) begin
                    load_s  = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    if (div_zero_s) begin
                        state_d = DIV_ZERO;
                    end else begin
                        state_d = DIV_ON;
                    end
                end else begin
                    busy_d  = 1'b0;
                    ready_d = 1'b0;
                end
            end

            DIV_ZERO: begin
                // Spends two cycles here so a zero divisor reports ready two
                // edges after acceptance.
                if (annul_i) begin
                    state_d = DIV_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b0;
                end else if (cnt_q == ONE_C) begin
                    state_d = DIV_END;
                    zfin_s  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b0;
                end else if (cnt_q == ITER_C) begin
                    state_d = DIV_END;
                    fin_s   = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    step_s = 1'b1;
                    cnt_d  = cnt_q + ONE_C;
                end
            end

            DIV_END: begin
                // Result is held until EX releases the request.
                if (!start_i) begin
                    state_d = DIV_IDLE;
                    ready_d = 1'b0;
                end else begin
                    ready_d = 1'b1;
                end
            end

            default: begin
                state_d = DIV_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    // Datapath registers: operands, partial remainder, sign flags and result
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dvd_q     <= {WIDTH{1'b0}};
            dvs_q     <= {WIDTH{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            result_q  <= {(2*WIDTH){1'b0}};
        end else begin
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            result_q  <= result_d;
        end
    end

    // Datapath next-state: operand capture, one restoring step, final result
    always_comb begin
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        result_d  = result_q;

        if (load_s) begin
            dvd_d     = op1_abs_s;
            dvs_d     = op2_abs_s;
            rem_d     = {WIDTH{1'b0}};
            dvd_neg_d = op1_neg_s;
            dvs_neg_d = op2_neg_s;
        end else if (step_s) begin
            if (ge_s) begin
                rem_d = diff_s[WIDTH-1:0];
            end else begin
                rem_d = rem_ext_s[WIDTH-1:0];
            end
            dvd_d = {dvd_q[WIDTH-2:0], ge_s};
        end else begin
            dvd_d = dvd_q;
        end

        if (fin_s) begin
            result_d = {rem_fix_s, quo_fix_s};
        end else if (zfin_s) begin
            result_d = {(2*WIDTH){1'b0}};
        end else begin
            result_d = result_q;
        end
    end

    assign busy_o   = busy_q;
    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic        busy_o;
    logic        ready_o;
    logic [63:0] result_o;

    int n_vec;
    int n_err;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .annul_i   (annul_i),
        .busy_o    (busy_o),
        .ready_o   (ready_o),
        .result_o  (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division in 64-bit arithmetic. SystemVerilog
    // truncates toward zero and gives the remainder the dividend's sign,
    // which is exactly DIV; the 0x80000000 / -1 case wraps when truncated to 32 bits.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue a divide and wait for ready_o; operands are scrambled right after
    // acceptance so a re-latch would corrupt the result. Leaves start_i high.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int lat);
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        @(posedge clk);
        #1;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~sgn;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (lat == 0) check("busy_after_accept", 64'(busy_o), 64'd1);
            if (ready_o) break;
            @(posedge clk);
            lat++;
        end
        res = result_o;
    endtask

    // Release the request and confirm the unit drops back to idle with the result kept.
    task automatic end_div(input logic [63:0] exp_res);
        start_i = 1'b0;
        @(negedge clk);
        check("ready_drop", 64'(ready_o), 64'd0);
        check("busy_idle", 64'(busy_o), 64'd0);
        check("result_kept", result_o, exp_res);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] exp;
        int          lat;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;

        n_vec = 0;
        n_err = 0;
        resetn    = 1'b0;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        annul_i   = 1'b0;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33};
        tbl[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    33};
        tbl[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},           33};
        tbl[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},           33};
        tbl[4] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'd0},           33};
        tbl[5] = '{1'b0, 32'd5,          32'd0,          64'd0,                           2};
        tbl[6] = '{1'b1, 32'd1000,       32'd10,         {32'd0, 32'd100},                33};
        tbl[7] = '{1'b0, 32'd0,          32'd3,          64'd0,                           33};
        tbl[8] = '{1'b0, 32'd3,          32'hFFFFFFFF,   {32'd3, 32'd0},                  33};
        tbl[9] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'd14},          33};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        resetn = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_div(tbl[i].sgn, tbl[i].a, tbl[i].b, res, lat);
            check($sformatf("tbl%0d_result", i), res, tbl[i].exp);
            check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
            end_div(tbl[i].exp);
        end

        // Zero divisor with the request held: ready stays up, no restart
        run_div(1'b0, 32'd1234, 32'd0, res, lat);
        check("dz_latency", 64'(lat), 64'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("dz_hold_ready", 64'(ready_o), 64'd1);
            check("dz_hold_busy", 64'(busy_o), 64'd0);
            check("dz_hold_result", result_o, 64'd0);
        end
        end_div(64'd0);

        // Establish a nonzero result, then annul a divide at cycle 10
        run_div(1'b0, 32'd100, 32'd7, res, lat);
        end_div({32'd2, 32'd14});
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd55555;
        opdata2_i = 32'd3;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_busy", 64'(busy_o), 64'd0);
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_result", result_o, {32'd2, 32'd14});
        run_div(1'b1, 32'd1000, 32'd10, res, lat);
        check("post_annul_result", res, {32'd0, 32'd100});
        check("post_annul_latency", 64'(lat), 64'd33);
        end_div({32'd0, 32'd100});

        // Start and annul together while idle: request is dropped
        @(negedge clk);
        start_i   = 1'b1;
        annul_i   = 1'b1;
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        check("start_annul_busy", 64'(busy_o), 64'd0);
        repeat (3) @(negedge clk);
        check("start_annul_ready", 64'(ready_o), 64'd0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd777;
        opdata2_i = 32'd5;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy_o), 64'd0);
        check("async_rst_ready", 64'(ready_o), 64'd0);
        check("async_rst_result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        resetn  = 1'b1;
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, res, lat);
        check("post_rst_result", res, {32'd0, 32'hFFFFFFFF});
        end_div({32'd0, 32'hFFFFFFFF});

        // Randomized operands against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
                default: b = $urandom;
            endcase
            exp = ref_div(sgn, a, b);
            run_div(sgn, a, b, res, lat);
            check($sformatf("rand%0d_result", i), res, exp);
            check($sformatf("rand%0d_latency", i), 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
            end_div(exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_div_unit
